// File: rtl/jk_seq_pkg.sv
// Shared op codes and FSM encoding for jk_bank_sequencer.
// The optional saturation feature is enabled by defining JK_SEQ_SATURATE_EN.
package jk_seq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
  localparam logic [OP_W-1:0] OP_SET    = 3'b001;
  localparam logic [OP_W-1:0] OP_CLEAR  = 3'b010;
  localparam logic [OP_W-1:0] OP_TOGGLE = 3'b011;
  localparam logic [OP_W-1:0] OP_UP     = 3'b100;
  localparam logic [OP_W-1:0] OP_DOWN   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset.
// JK truth table: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next-state decode of the JK pair
  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // Cell state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of WIDTH JK cells (hold/set/clear/toggle/up/down).
// Define JK_SEQ_SATURATE_EN to make UP/DOWN saturate and report it on sat.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             sat_q, sat_d;

  logic             run_en;
  logic             sat_hit;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;

  // Counter toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    logic acc_up;
    logic acc_dn;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    up_t   = {WIDTH{1'b0}};
    dn_t   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = acc_up;
      dn_t[i] = acc_dn;
      acc_up  = acc_up & q[i];
      acc_dn  = acc_dn & ~q[i];
    end
  end

  // Saturation detect: an UP at all-ones or a DOWN at zero is suppressed
  always_comb begin
    sat_hit = 1'b0;
`ifdef JK_SEQ_SATURATE_EN
    if ((op_q == OP_UP) && (&q)) begin
      sat_hit = 1'b1;
    end else if ((op_q == OP_DOWN) && (q == {WIDTH{1'b0}})) begin
      sat_hit = 1'b1;
    end else begin
      sat_hit = 1'b0;
    end
`else
    sat_hit = 1'b0;
`endif
  end

  // FSM next state and command/counter register updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    run_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          mask_d = cmd_mask;
          rem_d  = cmd_count;
          sat_d  = 1'b0;
          if (cmd_count != CNT_ZERO) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort wins over the pending update on the same edge
        if (cmd_abort) begin
          state_d = ST_DONE;
        end else begin
          run_en = 1'b1;
          if (sat_hit) begin
            sat_d = 1'b1;
          end else begin
            sat_d = sat_q;
          end
          if (rem_q == CNT_ONE) begin
            state_d = ST_DONE;
            rem_d   = CNT_ZERO;
          end else begin
            rem_d   = rem_q - CNT_ONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // J/K decode, active only on a non-aborted RUN edge
  always_comb begin
    j_s = {WIDTH{1'b0}};
    k_s = {WIDTH{1'b0}};
    if (run_en && !sat_hit) begin
      case (op_q)
        OP_HOLD: begin
          j_s = {WIDTH{1'b0}};
          k_s = {WIDTH{1'b0}};
        end
        OP_SET: begin
          j_s = mask_q;
          k_s = {WIDTH{1'b0}};
        end
        OP_CLEAR: begin
          j_s = {WIDTH{1'b0}};
          k_s = mask_q;
        end
        OP_TOGGLE: begin
          j_s = mask_q;
          k_s = mask_q;
        end
        OP_UP: begin
          j_s = up_t;
          k_s = up_t;
        end
        OP_DOWN: begin
          j_s = dn_t;
          k_s = dn_t;
        end
        default: begin
          j_s = {WIDTH{1'b0}};
          k_s = {WIDTH{1'b0}};
        end
      endcase
    end else begin
      j_s = {WIDTH{1'b0}};
      k_s = {WIDTH{1'b0}};
    end
  end

  // Control and command registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      mask_q  <= {WIDTH{1'b0}};
      rem_q   <= CNT_ZERO;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_s[gi]),
      .k   (k_s[gi]),
      .q   (q[gi])
    );
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign sat       = sat_q;

endmodule
